pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the 8-bit ALU.
- Consumes the ALU's take_branch and ovf outputs plus decode-supplied jump and offset fields, and produces the next instruction address each clock.
- Owns the overflow trap: saves the faulting PC, vectors to a handler, supports return, and halts on a double fault.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- EXC_VECTOR, 8'hF0, handler address loaded on overflow trap.
- FLUSH_CYCLES, 2, cycles spent in FLUSH after a trap (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  freeze all state for this cycle.
- take_branch  input  1  from ALU; branch condition met.
- branch_off  input  8  signed word offset, relative to pc+1.
- jump  input  1  unconditional jump this cycle.
- jump_target  input  8  absolute jump address.
- ovf  input  1  from ALU; signed overflow.
- ovf_check  input  1  current instruction traps on overflow.
- eret  input  1  return from exception handler.
- halt_req  input  1  software halt request.
- pc  output  8  current instruction address.
- epc  output  8  saved faulting PC.
- in_exc  output  1  executing inside the handler.
- flushing  output  1  FSM in FLUSH; decode must treat fetched instruction as NOP.
- halted  output  1  FSM in HALT.

Behaviour:
- One clock (clk). Reset is synchronous and active-high on port reset.
- All outputs are registered.
- Reset values: pc=RESET_PC, epc=8'h00, in_exc=0, flushing=0, halted=0, state=RUN, flush counter=0.
- All address arithmetic is 8-bit, modulo 256, with silent wrap.
  - 8'hFF+1 = 8'h00.
  - branch target = pc + 1 + branch_off, with branch_off sign-extended.
- States: RUN, FLUSH, HALT.
- RUN: per-cycle priority, highest first:
  1. halt_req -> HALT; pc holds.
  2. stall -> nothing changes.
  3. ovf&ovf_check&!in_exc -> epc<=pc, pc<=EXC_VECTOR, in_exc<=1, counter<=FLUSH_CYCLES-1, -> FLUSH.
  4. ovf&ovf_check&in_exc (double fault) -> HALT; epc unchanged; pc holds.
  5. eret&in_exc -> pc<=epc+1, in_exc<=0.
  6. eret&!in_exc -> pc<=pc+1 (treated as NOP).
  7. jump -> pc<=jump_target.
  8. take_branch -> pc<=branch target.
  9. otherwise -> pc<=pc+1.
- Mutually exclusive inputs: jump and take_branch asserted together resolve to jump. ovf without ovf_check is ignored.
- FLUSH:
  - flushing=1.
  - pc holds EXC_VECTOR.
  - All control inputs except halt_req and stall are ignored.
  - Counter decrements each unstalled cycle; when it reaches 0 -> RUN.
  - Total unstalled FLUSH cycles = FLUSH_CYCLES.
  - stall freezes the counter.
  - halt_req -> HALT immediately.
- HALT:
  - Absorbing state; only reset leaves it.
  - halted=1; pc, epc and in_exc frozen.
- Latency: next-PC decisions take effect on the next rising edge (one cycle).
- Reset mid-trap or mid-FLUSH restores every reset value on the next edge. Reset overrides stall and halt_req.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- Defined:
  - Adds output port branch_count (8 bits, reset 0).
  - Increments on every RUN cycle where a branch is taken (take_branch & !jump & no higher-priority event & !stall).
  - Saturates at 8'hFF.
  - Does not count jumps, erets or traps.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then 3 idle cycles -> pc 00,01,02,03; flushing=0, halted=0.
- pc=8'h10, take_branch=1, branch_off=8'hFC (-4) -> pc=8'h0D next cycle. Also pc=8'hFF with no branch -> pc=8'h00 (wrap).
- pc=8'h22, jump=1, jump_target=8'h40, take_branch=1 -> pc=8'h40 (jump wins). Repeat with stall=1 -> pc stays 8'h22.
- pc=8'h31, ovf=1, ovf_check=1 -> epc=8'h31, pc=8'hF0, in_exc=1, flushing=1 for exactly 2 cycles (3 with one stall inserted). Then eret -> pc=8'h32, in_exc=0.
- Inside handler (in_exc=1), ovf=1, ovf_check=1 -> halted=1, pc frozen, epc still 8'h31. Inputs ignored until reset=1 -> pc=8'h00, halted=0, in_exc=0.
- With PC_BRANCH_STATS_EN: 260 taken branches -> branch_count=8'hFF. A concurrent jump+take_branch does not increment; reset clears to 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter stage with overflow trap, flush window and halt.
// Optional macro PC_BRANCH_STATS_EN adds a saturating taken-branch counter.
module pc_sequencer #(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter logic [7:0] EXC_VECTOR   = 8'hF0,
  parameter int         FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       take_branch,
  input  logic [7:0] branch_off,
  input  logic       jump,
  input  logic [7:0] jump_target,
  input  logic       ovf,
  input  logic       ovf_check,
  input  logic       eret,
  input  logic       halt_req,
  output logic [7:0] pc,
  output logic [7:0] epc,
  output logic       in_exc,
  output logic       flushing,
  output logic       halted,
`ifdef PC_BRANCH_STATS_EN
  output logic [7:0] branch_count,
`endif
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] epc_q, epc_d;
  logic       in_exc_q, in_exc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       flushing_q, halted_q;
  logic       br_taken;
  logic       trap_hit;

  assign trap_hit = ovf && ovf_check;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    in_exc_d = in_exc_q;
    cnt_d    = cnt_q;
    br_taken = 1'b0;
    case (state_q)
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (stall) begin
          state_d = S_RUN;
        end else if (trap_hit && !in_exc_q) begin
          epc_d    = pc_q;
          pc_d     = EXC_VECTOR;
          in_exc_d = 1'b1;
          cnt_d    = FLUSH_LOAD;
          state_d  = S_FLUSH;
        end else if (trap_hit) begin
          state_d = S_HALT;
        end else if (eret && in_exc_q) begin
          pc_d     = epc_q + 8'd1;
          in_exc_d = 1'b0;
        end else if (eret) begin
          pc_d = pc_q + 8'd1;
        end else if (jump) begin
          pc_d = jump_target;
        end else if (take_branch) begin
          // 8-bit add wraps, so sign extension of the offset is implicit.
          pc_d     = pc_q + 8'd1 + branch_off;
          br_taken = 1'b1;
        end else begin
          pc_d = pc_q + 8'd1;
        end
      end
      S_FLUSH: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (!stall) begin
          if (cnt_q == 8'd0) state_d = S_RUN;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      epc_q      <= 8'h00;
      in_exc_q   <= 1'b0;
      cnt_q      <= 8'd0;
      flushing_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      in_exc_q   <= in_exc_d;
      cnt_q      <= cnt_d;
      flushing_q <= (state_d == S_FLUSH);
      halted_q   <= (state_d == S_HALT);
    end
  end

`ifdef PC_BRANCH_STATS_EN
  logic [7:0] br_cnt_q, br_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    if (br_taken && br_cnt_q != 8'hFF) br_cnt_d = br_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) br_cnt_q <= 8'h00;
    else       br_cnt_q <= br_cnt_d;
  end

  assign branch_count = br_cnt_q;
`else
  logic unused_br;
  assign unused_br = br_taken;
`endif

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign in_exc    = in_exc_q;
  assign flushing  = flushing_q;
  assign halted    = halted_q;
  assign dbg_state = state_q;

endmodule
